// File: rtl/buffer_unpack.sv
// Word-to-chunk unpacker: 2-entry word FIFO feeding a shift register that emits
// OUT_W-bit chunks MSB-first. Optional out_parity port under `UNPACK_PARITY_EN.
module buffer_unpack #(
  parameter int WIDTH = 16,
  parameter int OUT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             drop_pulse,
`ifdef UNPACK_PARITY_EN
  output logic             out_parity,
`endif
  output logic [7:0]       drop_count
);

  localparam int CHUNKS = WIDTH / OUT_W;
  localparam int IDX_W  = $clog2(CHUNKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sreg;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr, wr_ptr;
  logic [1:0]       count;

  logic hs, last_hs, accept, load_direct, pop, push, drop;

  // A full FIFO can still take a word when the active word retires this cycle,
  // since the head moves into the shift register and frees its slot.
  always_comb begin
    hs          = out_valid & out_ready;
    last_hs     = hs & (idx == LAST_IDX);
    accept      = in_valid & ((count != 2'd2) | last_hs);
    load_direct = accept & ((state == IDLE) | (last_hs & (count == 2'd0)));
    pop         = last_hs & (count != 2'd0);
    push        = accept & ~load_direct;
    drop        = in_valid & ~accept;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    case (state)
      IDLE: begin
        if (load_direct) state_next = SHIFT;
      end
      SHIFT: begin
        out_valid = 1'b1;
        out_last  = (idx == LAST_IDX);
        if (last_hs && !pop && !load_direct) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign out_data = sreg[WIDTH-1 -: OUT_W];

`ifdef UNPACK_PARITY_EN
  assign out_parity = out_valid & (^out_data);
`endif

  // Active word: new words enter at index 0; each handshake exposes the next chunk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
      idx  <= '0;
    end else if (load_direct) begin
      sreg <= in_data;
      idx  <= '0;
    end else if (pop) begin
      sreg <= mem[rd_ptr];
      idx  <= '0;
    end else if (hs) begin
      sreg <= sreg << OUT_W;
      idx  <= idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_pulse <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      drop_pulse <= drop;
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_buffer_unpack.sv
// Directed bench for buffer_unpack (WIDTH=16, OUT_W=4). Inputs change and
// outputs are sampled on the falling edge.
module tb_buffer_unpack;
  localparam int WIDTH = 16;
  localparam int OUT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             out_last;
  logic             drop_pulse;
  logic [7:0]       drop_count;
`ifdef UNPACK_PARITY_EN
  logic             out_parity;
`endif

  int vectors = 0;
  int miscompares = 0;

  buffer_unpack #(.WIDTH(WIDTH), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .drop_pulse(drop_pulse),
`ifdef UNPACK_PARITY_EN
    .out_parity(out_parity),
`endif
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 4'h0 || out_last !== 1'b0 ||
        drop_pulse !== 1'b0 || drop_count !== 8'd0) begin
      miscompares++;
      $display("FAIL reset: valid=%b data=%h last=%b drop=%b cnt=%0d, want all 0",
               out_valid, out_data, out_last, drop_pulse, drop_count);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_single();
    logic [3:0] exp [4] = '{4'hA, 4'h5, 4'hC, 4'h3};
    logic want_last;
    in_data = 16'hA5C3; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); in_valid = 1'b0;
      want_last = (i == 3);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== exp[i] || out_last !== want_last) begin
        miscompares++;
        $display("FAIL single_c%0d: valid=%b data=%h last=%b, want 1 %h %b",
                 i, out_valid, out_data, out_last, exp[i], want_last);
      end
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || out_last !== 1'b0) begin
      miscompares++;
      $display("FAIL single_idle: valid=%b last=%b, want 0 0", out_valid, out_last);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp [8] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hA, 4'hB, 4'hC, 4'hD};
    logic want_last;
    in_data = 16'h1234; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      want_last = (i == 3 || i == 7);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== exp[i] || out_last !== want_last) begin
        miscompares++;
        $display("FAIL b2b_c%0d: valid=%b data=%h last=%b, want 1 %h %b",
                 i, out_valid, out_data, out_last, exp[i], want_last);
      end
      if (i == 3) begin in_data = 16'hABCD; in_valid = 1'b1; end
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_stall();
    logic [3:0] exp [7] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF};
    logic want_last;
    in_data = 16'hF00F; in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = (i >= 3);
      want_last = (i == 6);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== exp[i] || out_last !== want_last) begin
        miscompares++;
        $display("FAIL stall_s%0d: valid=%b data=%h last=%b, want 1 %h %b",
                 i, out_valid, out_data, out_last, exp[i], want_last);
      end
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_idle: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_drop();
    logic [15:0] words [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    logic [3:0] want_data;
    logic want_pulse;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin in_data = words[i]; in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(negedge clk);
      want_pulse = (i == 3);
      vectors++;
      if (drop_pulse !== want_pulse) begin
        miscompares++;
        $display("FAIL drop_pulse_t%0d: got %b, want %b", i, drop_pulse, want_pulse);
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (drop_count !== 8'd1 || out_data !== 4'h1) begin
      miscompares++;
      $display("FAIL drop_count: cnt=%0d data=%h, want 1 1", drop_count, out_data);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      want_data = 4'(i / 4 + 1);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== want_data) begin
        miscompares++;
        $display("FAIL drop_drain_c%0d: valid=%b data=%h, want 1 %h",
                 i, out_valid, out_data, want_data);
      end
      @(negedge clk);
    end
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_idle: valid=%b, want 0", out_valid);
    end
  endtask

  // FIFO full: a strobe coinciding with the last-chunk handshake must be kept.
  task automatic test_full_pop_push();
    logic [15:0] words [3] = '{16'h1111, 16'h2222, 16'h3333};
    logic [3:0] want_data;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = words[i]; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      want_data = 4'(i / 4 + 1);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== want_data || drop_pulse !== 1'b0) begin
        miscompares++;
        $display("FAIL full_c%0d: valid=%b data=%h drop=%b, want 1 %h 0",
                 i, out_valid, out_data, drop_pulse, want_data);
      end
      if (i == 3) begin in_data = 16'h4444; in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(negedge clk);
    end
    vectors++;
    if (out_valid !== 1'b0 || drop_count !== 8'd1) begin
      miscompares++;
      $display("FAIL full_end: valid=%b cnt=%0d, want 0 1", out_valid, drop_count);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    in_data = 16'hA5C3; in_valid = 1'b1;
    @(negedge clk);
    in_data = 16'h1234; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (out_data !== 4'h5) begin
      miscompares++;
      $display("FAIL rmid_pre: data=%h, want 5", out_data);
    end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 4'h0 || out_last !== 1'b0 ||
        drop_pulse !== 1'b0 || drop_count !== 8'd0) begin
      miscompares++;
      $display("FAIL rmid_async: valid=%b data=%h last=%b drop=%b cnt=%0d, want all 0",
               out_valid, out_data, out_last, drop_pulse, drop_count);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rmid_quiet_t%0d: valid=%b data=%h, want 0", i, out_valid, out_data);
      end
    end
    in_data = 16'hBEEF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 4'hB) begin
      miscompares++;
      $display("FAIL rmid_restart: valid=%b data=%h, want 1 b", out_valid, out_data);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_end: valid=%b, want 0", out_valid);
    end
  endtask

`ifdef UNPACK_PARITY_EN
  task automatic test_parity();
    logic exp [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    in_data = 16'h7E10; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); in_valid = 1'b0;
      vectors++;
      if (out_parity !== exp[i]) begin
        miscompares++;
        $display("FAIL parity_c%0d: got %b, want %b", i, out_parity, exp[i]);
      end
    end
    @(negedge clk);
    vectors++;
    if (out_parity !== 1'b0) begin
      miscompares++;
      $display("FAIL parity_idle: got %b, want 0", out_parity);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_drop();
    test_full_pop_push();
    test_reset_mid();
`ifdef UNPACK_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/buffer_unpack.md
BUFFER_UNPACK -- requirements
Module: buffer_unpack

Interface
REQ-001 Parameter WIDTH, default 16: bit width of each input word.
REQ-002 Parameter OUT_W, default 4: bit width of each output chunk; WIDTH SHALL be an integer multiple of OUT_W, with CHUNKS = WIDTH/OUT_W >= 2.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_data  input  WIDTH  word from the upstream capture register.
REQ-006 in_valid  input  1  one-cycle strobe; in_data is valid this cycle.
REQ-007 out_data  output  OUT_W  current chunk, MSB-first.
REQ-008 out_valid  output  1  out_data is valid.
REQ-009 out_ready  input  1  downstream accepts the chunk when high together with out_valid.
REQ-010 out_last  output  1  high with out_valid on the final chunk of a word.
REQ-011 drop_pulse  output  1  one-cycle pulse when an input word is discarded.
REQ-012 drop_count  output  8  saturating count of discarded words.

Function
REQ-013 The block SHALL hold a 2-entry word FIFO plus one shift register for the active word, and run a two-state FSM: IDLE and SHIFT.
- IDLE: out_valid=0.
- SHIFT: out_valid=1.
REQ-014 A push SHALL be accepted when in_valid=1 and the FIFO holds fewer than 2 words, or when it holds 2 words and the head's last chunk is accepted in the same cycle.
REQ-015 In IDLE with the FIFO empty, an accepted in_valid SHALL load the word directly into the shift register and enter SHIFT; out_valid rises the cycle after the strobe (latency 1).
REQ-016 In SHIFT, out_data SHALL equal the top OUT_W bits of the shift register.
REQ-017 Each handshake (out_valid & out_ready) SHALL shift the register left by OUT_W and increment a chunk index in the range 0..CHUNKS-1.
REQ-018 out_last SHALL be high iff chunk index = CHUNKS-1 and the FSM is in SHIFT.
REQ-019 On the handshake of the last chunk:
- FIFO non-empty: pop the head into the shift register, reset the index to 0, stay in SHIFT (no bubble cycle).
- FIFO empty and in_valid accepted in the same cycle: load in_data directly and stay in SHIFT.
- Otherwise: enter IDLE.
REQ-020 With out_ready=0, out_data, out_last and the chunk index SHALL hold their values.
REQ-021 in_valid rejected under REQ-014 SHALL assert drop_pulse for exactly one cycle and increment drop_count, which saturates at 255; the FIFO contents are unchanged.
REQ-022 Words SHALL leave the block in arrival order, and every accepted word SHALL be emitted as exactly CHUNKS chunks.

Reset
REQ-023 While rst=1: FSM=IDLE, FIFO empty, shift register and index zero, out_data=0, out_valid=0, out_last=0, drop_pulse=0, drop_count=0.
REQ-024 Reset asserted mid-word SHALL discard the partial word and all FIFO contents; the first strobe after release is handled as in REQ-015.

Configuration
REQ-025 Macro UNPACK_PARITY_EN: when defined, the block SHALL add output out_parity (1 bit), equal to the XOR of the out_data bits, valid whenever out_valid=1 and 0 otherwise.
REQ-026 When UNPACK_PARITY_EN is undefined, out_parity and its logic SHALL be absent; all other behaviour is identical.

Verification (WIDTH=16, OUT_W=4)
REQ-027 Push 0xA5C3, out_ready=1 -> out_data A,5,C,3 on cycles 1-4 after the strobe; out_last only on the 3; IDLE on cycle 5.
REQ-028 Strobes 0x1234 then 0xABCD four cycles apart, out_ready=1 -> 8 contiguous chunks 1,2,3,4,A,B,C,D with no bubble.
REQ-029 Push 0xF00F, out_ready low for 3 cycles after the first chunk -> out_data holds F through the stall, then 0,0,F.
REQ-030 out_ready=0, four strobes 0x1111, 0x2222, 0x3333, 0x4444 -> the 4th word is dropped, drop_pulse one cycle, drop_count=1; release out_ready -> 1,1,1,1,2,2,2,2,3,3,3,3.
REQ-031 Assert rst during the 2nd chunk of 0xA5C3 with 0x1234 queued -> all outputs 0; no chunks after release until a new strobe.
REQ-032 With UNPACK_PARITY_EN defined, push 0x7E10 -> out_parity 1,1,1,0.
